// File: rtl/key_entry_pkg.sv
// key_entry_pkg: shared key codes, display constants and the hex glyph table.
//   KEY_STAR  - backspace key code
//   KEY_HASH  - clear key code
//   SEG_BLANK - all segments off (active-low)
//   SEG_TABLE - hex digit to {CA,CB,CC,CD,CE,CF,CG,DP}, active-low, DP always off
package key_entry_pkg;

    typedef logic [3:0]       key_code_t;
    typedef logic [7:0][3:0]  slot_array_t;

    localparam key_code_t  KEY_STAR  = 4'd14;
    localparam key_code_t  KEY_HASH  = 4'd15;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Index 15 is leftmost, so SEG_TABLE[code] yields the glyph for code.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
        8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
        8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
        8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
    };

    function automatic logic [7:0] seg_of(input key_code_t code);
        return SEG_TABLE[code];
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit seven-segment display.
// Holds each digit for SCAN_DIV cycles, then moves to the next (0..7, wrap).
//   clk, reset  - clock, asynchronous active-high reset
//   slots       - eight 4-bit digit codes, slot 0 rightmost
//   slot_valid  - per-slot valid; invalid slots show blank
//   led_en      - registered digit enables, active-low
//   led_cx      - registered segments, active-low
module seg7_scan
    import key_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  slot_array_t slots,
    input  logic [7:0]  slot_valid,
    output logic [7:0]  led_en,
    output logic [7:0]  led_cx
);

    localparam int unsigned     CntW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      index_q, index_d;
    logic [7:0]      led_en_q, led_en_d;
    logic [7:0]      led_cx_q, led_cx_d;
    logic            wrap;

    always_comb begin
        wrap     = (cnt_q == CntMax);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        index_d  = wrap ? index_q + 3'd1 : index_q;
        // Outputs are built from the current index and buffer, giving one cycle of latency.
        led_en_d = ~(8'h01 << index_q);
        led_cx_d = slot_valid[index_q] ? seg_of(slots[index_q]) : SEG_BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            index_q  <= 3'd0;
            led_en_q <= 8'hFE;
            led_cx_q <= SEG_BLANK;
        end else begin
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            led_en_q <= led_en_d;
            led_cx_q <= led_cx_d;
        end
    end

    assign led_en = led_en_q;
    assign led_cx = led_cx_q;

endmodule

// File: rtl/key_entry_display.sv
// key_entry_display: keypad entry buffer (up to 8 digits) with multiplexed display.
// Digit keys (0-13) shift in at the right, '*' deletes the newest, '#' clears.
// Build option: define KEY_ENTRY_EDGE_EN to accept only rising edges of keyboard_en;
// otherwise every cycle with keyboard_en high is a key.
//   clk, reset    - clock, asynchronous active-high reset
//   keyboard_en   - key-valid strobe
//   keyboard_num  - key code
//   led_en/led_cx - display enables / segments, active-low
//   digit_count   - digits held (0-8); full - digit_count == 8
module key_entry_display
    import key_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyboard_en,
    input  logic [3:0] keyboard_num,
    output logic [7:0] led_en,
    output logic [7:0] led_cx,
    output logic [3:0] digit_count,
    output logic       full
);

    logic        accept;
    slot_array_t slots_q, slots_d;
    logic [7:0]  valid_q, valid_d;
    logic [3:0]  count_q, count_d;

`ifdef KEY_ENTRY_EDGE_EN
    // Resets high so a strobe held through reset release is not taken as a key.
    logic en_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_prev_q <= 1'b1;
        end else begin
            en_prev_q <= keyboard_en;
        end
    end

    assign accept = keyboard_en & ~en_prev_q;
`else
    assign accept = keyboard_en;
`endif

    always_comb begin
        slots_d = slots_q;
        valid_d = valid_q;
        count_d = count_q;
        if (accept) begin
            if (keyboard_num == KEY_HASH) begin
                slots_d = '0;
                valid_d = '0;
                count_d = 4'd0;
            end else if (keyboard_num == KEY_STAR) begin
                if (count_q != 4'd0) begin
                    slots_d = {4'h0, slots_q[7:1]};
                    valid_d = {1'b0, valid_q[7:1]};
                    count_d = count_q - 4'd1;
                end
            end else if (count_q != 4'd8) begin
                slots_d = {slots_q[6:0], keyboard_num};
                valid_d = {valid_q[6:0], 1'b1};
                count_d = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots_q <= '0;
            valid_q <= '0;
            count_q <= 4'd0;
        end else begin
            slots_q <= slots_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign digit_count = count_q;
    assign full        = (count_q == 4'd8);

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .slots     (slots_q),
        .slot_valid(valid_q),
        .led_en    (led_en),
        .led_cx    (led_cx)
    );

endmodule

// File: doc/key_entry_display.md
KEY_ENTRY_DISPLAY -- requirements
Module: key_entry_display

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles each display digit is held (1 ms at 100 MHz); legal range 2 to 2^20.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 keyboard_en  input  1  key-valid strobe from the keypad scanner.
REQ-005 keyboard_num  input  4  key code, sampled when keyboard_en=1: 0-9 digits, 10-13 A-D, 14 '*', 15 '#'.
REQ-006 led_en  output  8  digit enables, active-low, bit 0 = rightmost digit.
REQ-007 led_cx  output  8  segments {CA,CB,CC,CD,CE,CF,CG,DP}, active-low (0 = lit).
REQ-008 digit_count  output  4  number of entered digits, 0-8.
REQ-009 full  output  1  high exactly when digit_count==8.

Function
REQ-010 An accepted key is one with keyboard_en=1 in a cycle (per REQ-027/028); all buffer and count updates are registered and visible the cycle after acceptance.
REQ-011 Buffer: eight 4-bit slots, slot 0 newest (rightmost), plus a valid bit per slot; slots at index >= digit_count are invalid.
REQ-012 Codes 0-13 with digit_count<8: slots shift up one (slot i+1 <= slot i), slot 0 <= code, digit_count += 1.
REQ-013 Codes 0-13 with digit_count==8: ignored; buffer, count and full unchanged.
REQ-014 Code 14 ('*', backspace) with digit_count>0: slots shift down (slot i <= slot i+1), slot 7 invalid, digit_count -= 1; with digit_count==0 ignored.
REQ-015 Code 15 ('#', clear): all slots invalid, digit_count <= 0, regardless of prior count.
REQ-016 Scan: a counter counts 0 to SCAN_DIV-1 then wraps; on wrap the digit index advances 0,1,...,7,0.
REQ-017 led_en is all ones except bit [index], which is 0; exactly one enable is active every cycle outside reset.
REQ-018 led_cx shows hex glyph of slot[index] (0-9, A, b, C, d) when the slot is valid; 8'hFF (blank) when invalid.
REQ-019 DP segment is off (1) in all cases unless REQ-029 applies.
REQ-020 Key acceptance and scan advance are independent; a key accepted in the scan wrap cycle is displayed from its next-cycle state without disturbing scan timing.
REQ-021 led_en and led_cx are registered; they reflect the index and buffer of the previous cycle (1-cycle latency).

Reset
REQ-022 Reset asserted at any time, including mid-scan or in a key-strobe cycle, takes effect immediately and dominates every other event.
REQ-023 Reset values: all slots invalid, digit_count=0, full=0, scan counter=0, index=0, led_en=8'hFE, led_cx=8'hFF.
REQ-024 The edge-detect history register (REQ-028) resets to 1, so a strobe held high through reset release is not accepted.
REQ-025 After reset release, the first scan wrap occurs SCAN_DIV cycles later.

Configuration
REQ-026 Macro KEY_ENTRY_EDGE_EN selects strobe qualification.
REQ-027 Undefined: keyboard_en is a single-cycle pulse; every cycle with keyboard_en=1 is an accepted key.
REQ-028 Defined: only a 0-to-1 transition of keyboard_en (registered previous value 0, current 1) is accepted; holding it high yields one key.
REQ-029 Both builds: none; DP is never lit (REQ-019 holds unconditionally).

Structure
REQ-030 Package key_entry_pkg holds key code constants (KEY_STAR=14, KEY_HASH=15), SEG_BLANK=8'hFF, and the 16-entry hex to active-low segment table.
REQ-031 Sub-module seg7_scan holds the scan counter, digit index and led_en/led_cx registers; it takes the eight slots and valid bits as inputs.
REQ-032 key_entry_display holds strobe qualification, the buffer, digit_count and full.

Verification (SCAN_DIV=4)
REQ-033 Reset, then keys 1,2,3 -> digit_count=3; index0 led_cx=8'h0D ('3'), index1 8'h25 ('2'), index2 8'h9F ('1'), indexes 3-7 8'hFF.
REQ-034 Nine digit keys 0-8 -> full=1, digit_count=8, slot 0 shows '7'; the ninth key ('8') changes nothing.
REQ-035 Keys 5,6 then '*' -> digit_count=1, slot0='5'; '*' twice more -> digit_count=0 both times, no underflow.
REQ-036 Four digits then '#' -> digit_count=0, full=0, all led_cx=8'hFF for a full 32-cycle scan.
REQ-037 keyboard_en held high 10 cycles with code 9 -> 10 keys accepted without KEY_ENTRY_EDGE_EN (digit_count=8, full=1); 1 key with it defined (digit_count=1).
REQ-038 Reset pulse asserted mid-scan with a strobe in the same cycle -> outputs equal REQ-023 values that cycle; the key is not captured.
